// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, mover FSM states and the per-axis bounce step
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } mover_state_t;

  typedef struct packed {
    coord_t pos;
    logic   dir;
  } axis_t;

  // One step along an axis; the extra bit keeps pos+step from wrapping near the far edge.
  function automatic axis_t axis_step(input coord_t pos, input logic dir,
                                      input coord_ext_t max_pos, input coord_ext_t step);
    coord_ext_t w_sum;
    axis_t      r;
    r.pos = pos;
    r.dir = dir;
    w_sum = '0;
    if (dir) begin
      w_sum = {1'b0, pos} + step;
      if (w_sum >= max_pos) begin
        r.pos = max_pos[COORD_W-1:0];
        r.dir = 1'b0;
      end else begin
        r.pos = w_sum[COORD_W-1:0];
      end
    end else begin
      if ({1'b0, pos} <= step) begin
        r.pos = '0;
        r.dir = 1'b1;
      end else begin
        w_sum = {1'b0, pos} - step;
        r.pos = w_sum[COORD_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchroniser with one-cycle rising-edge pulse
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/square_mover.sv
// rtl/square_mover.sv - steps a bouncing square once per slow tick, applied only in vertical blanking
module square_mover #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int SIZE     = 32,
  parameter int STEP     = 4,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0
) (
  input  logic                        fastClk,
  input  logic                        rstn,
  input  logic                        slowClk,
  input  logic                        enable,
  input  logic                        blank_v,
  input  logic [vga_pkg::COORD_W-1:0] hcount,
  input  logic [vga_pkg::COORD_W-1:0] vcount,
  output logic [vga_pkg::COORD_W-1:0] sq_x,
  output logic [vga_pkg::COORD_W-1:0] sq_y,
  output logic                        dir_x,
  output logic                        dir_y,
  output logic                        moved,
  output logic                        red_on
);

  import vga_pkg::*;

  localparam coord_ext_t X_MAX  = coord_ext_t'(H_ACTIVE - SIZE);
  localparam coord_ext_t Y_MAX  = coord_ext_t'(V_ACTIVE - SIZE);
  localparam coord_ext_t STEP_E = coord_ext_t'(STEP);
  localparam coord_ext_t SIZE_E = coord_ext_t'(SIZE);

  mover_state_t r_state;
  mover_state_t w_state_nxt;
  logic         w_tick;
  logic         w_apply;
  axis_t        w_nx;
  axis_t        w_ny;
  coord_t       r_sq_x;
  coord_t       r_sq_y;
  logic         r_dir_x;
  logic         r_dir_y;
  logic         r_moved;
  logic         r_red_on;
  logic         w_in_x;
  logic         w_in_y;

  // slowClk is only ever sampled as data in the pixel domain.
  sync_edge_detect u_slow_edge (
    .i_clk   (fastClk),
    .i_rst_n (rstn),
    .i_d     (slowClk),
    .o_rise  (w_tick)
  );

  always_ff @(posedge fastClk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ticks arriving while PEND are absorbed: one step per PEND visit.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && enable) begin
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (blank_v) begin
          w_apply     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_nx = axis_step(r_sq_x, r_dir_x, X_MAX, STEP_E);
  assign w_ny = axis_step(r_sq_y, r_dir_y, Y_MAX, STEP_E);

  always_ff @(posedge fastClk or negedge rstn) begin
    if (!rstn) begin
      r_sq_x  <= coord_t'(X_INIT);
      r_sq_y  <= coord_t'(Y_INIT);
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
      r_moved <= 1'b0;
    end else begin
      r_moved <= w_apply;
      if (w_apply) begin
        r_sq_x  <= w_nx.pos;
        r_dir_x <= w_nx.dir;
        r_sq_y  <= w_ny.pos;
        r_dir_y <= w_ny.dir;
      end
    end
  end

  assign w_in_x = ({1'b0, hcount} >= {1'b0, r_sq_x}) && ({1'b0, hcount} < ({1'b0, r_sq_x} + SIZE_E));
  assign w_in_y = ({1'b0, vcount} >= {1'b0, r_sq_y}) && ({1'b0, vcount} < ({1'b0, r_sq_y} + SIZE_E));

  always_ff @(posedge fastClk or negedge rstn) begin
    if (!rstn) begin
      r_red_on <= 1'b0;
    end else begin
      r_red_on <= w_in_x && w_in_y;
    end
  end

  assign sq_x   = r_sq_x;
  assign sq_y   = r_sq_y;
  assign dir_x  = r_dir_x;
  assign dir_y  = r_dir_y;
  assign moved  = r_moved;
  assign red_on = r_red_on;

endmodule
